shot_trigger_ctrl: RTL and testbench

SHOT_TRIGGER_CTRL -- requirements
Module: shot_trigger_ctrl

---
 rtl/shot_trigger_ctrl.sv | 124 ++++++++++++
 tb/tb_shot_trigger_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_trigger_ctrl.sv
// Shot trigger controller: edge-detected fire/reload keys, per-frame cooldown
// and reload timing, magazine bookkeeping and one-clk launch pulse.
module shot_trigger_ctrl #(
  parameter int unsigned MAX_AMMO        = 8,
  parameter int unsigned COOLDOWN_FRAMES = 6,
  parameter int unsigned RELOAD_FRAMES   = 45
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       fireKey,
  input  logic       reloadKey,
  input  logic [2:0] dirIn,
  input  logic       shotFree,
  input  logic       pause,
  output logic       triggerShot,
  output logic [2:0] shotDirection,
  output logic [3:0] ammoCount,
  output logic       reloading,
  output logic [7:0] shotsFired
);

  localparam int unsigned CNT_MAX = (COOLDOWN_FRAMES > RELOAD_FRAMES) ? COOLDOWN_FRAMES
                                                                      : RELOAD_FRAMES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COOLDOWN = 2'd1,
    RELOAD   = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   frame_cnt, cnt_d;
  logic            fire_q, reload_q;
  logic            trig_d;
  logic [2:0]      dir_d;
  logic [3:0]      ammo_d;
  logic [7:0]      fired_d;
  logic            fire_rise, reload_rise, frame_tick, cnt_last;

  assign fire_rise   = fireKey & ~fire_q;
  assign reload_rise = reloadKey & ~reload_q;
  assign frame_tick  = startOfFrame & ~pause;
  assign cnt_last    = frame_tick && (frame_cnt == CW'(1));
  assign reloading   = (state == RELOAD);

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_d;
  end

  // Datapath and key history registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fire_q        <= 1'b0;
      reload_q      <= 1'b0;
      frame_cnt     <= '0;
      triggerShot   <= 1'b0;
      shotDirection <= 3'd0;
      ammoCount     <= 4'(MAX_AMMO);
      shotsFired    <= 8'd0;
    end else begin
      fire_q        <= fireKey;
      reload_q      <= reloadKey;
      frame_cnt     <= cnt_d;
      triggerShot   <= trig_d;
      shotDirection <= dir_d;
      ammoCount     <= ammo_d;
      shotsFired    <= fired_d;
    end
  end

  // Next-state and next-output logic; everything holds while paused
  always_comb begin
    state_d = state;
    cnt_d   = frame_cnt;
    trig_d  = 1'b0;
    dir_d   = shotDirection;
    ammo_d  = ammoCount;
    fired_d = shotsFired;
    if (!pause) begin
      if (frame_tick && (frame_cnt != '0)) cnt_d = frame_cnt - CW'(1);
      case (state)
        IDLE: begin
          // A fire rise claims the cycle: a simultaneous reload rise is dropped
          // even when the launch itself is refused.
          if (fire_rise) begin
            if ((ammoCount != 4'd0) && shotFree) begin
              trig_d  = 1'b1;
              dir_d   = dirIn;
              ammo_d  = ammoCount - 4'd1;
              fired_d = shotsFired + 8'd1;
              cnt_d   = CW'(COOLDOWN_FRAMES);
              state_d = COOLDOWN;
            end
          end else if (reload_rise && (ammoCount < 4'(MAX_AMMO))) begin
            cnt_d   = CW'(RELOAD_FRAMES);
            state_d = RELOAD;
          end
        end
        COOLDOWN: begin
          if (cnt_last) begin
            if (ammoCount != 4'd0) begin
              state_d = IDLE;
            end else begin
              cnt_d   = CW'(RELOAD_FRAMES);
              state_d = RELOAD;
            end
          end
        end
        RELOAD: begin
          if (cnt_last) begin
            ammo_d  = 4'(MAX_AMMO);
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_trigger_ctrl.sv
// Bench for shot_trigger_ctrl: directed scenarios plus randomized stimulus
// against a frame-counting behavioural model.
module tb_shot_trigger_ctrl;

  localparam int MAXA = 8;
  localparam int CD   = 6;
  localparam int RL   = 45;

  logic       clk, resetN, startOfFrame, fireKey, reloadKey, shotFree, pause;
  logic [2:0] dirIn;
  logic       triggerShot, reloading;
  logic [2:0] shotDirection;
  logic [3:0] ammoCount;
  logic [7:0] shotsFired;

  int total = 0;
  int bad   = 0;
  int trig_seen = 0;

  // Behavioural model: mode 0 idle, 1 cooldown, 2 reload; frames counted up
  int       m_mode, m_elapsed, m_ammo, m_shots;
  logic [2:0] m_dir;
  bit       m_trig, m_fp, m_rp;

  shot_trigger_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireKey(fireKey),
    .reloadKey(reloadKey), .dirIn(dirIn), .shotFree(shotFree), .pause(pause),
    .triggerShot(triggerShot), .shotDirection(shotDirection), .ammoCount(ammoCount),
    .reloading(reloading), .shotsFired(shotsFired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] dut_state();
    return dut.state;
  endfunction

  function automatic logic [5:0] dut_cnt();
    return dut.frame_cnt;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_elapsed = 0; m_ammo = MAXA; m_shots = 0;
    m_dir = 3'd0; m_trig = 0; m_fp = 0; m_rp = 0;
  endtask

  task automatic model_step();
    bit fr, rr;
    fr = fireKey && !m_fp;
    rr = reloadKey && !m_rp;
    m_fp = fireKey;
    m_rp = reloadKey;
    m_trig = 0;
    if (pause) return;
    case (m_mode)
      0: begin
        if (fr) begin
          if (m_ammo > 0 && shotFree) begin
            m_trig = 1; m_dir = dirIn; m_ammo--; m_shots = (m_shots + 1) % 256;
            m_mode = 1; m_elapsed = 0;
          end
        end else if (rr && m_ammo < MAXA) begin
          m_mode = 2; m_elapsed = 0;
        end
      end
      1: if (startOfFrame) begin
        m_elapsed++;
        if (m_elapsed == CD) begin
          m_mode = (m_ammo > 0) ? 0 : 2;
          m_elapsed = 0;
        end
      end
      default: if (startOfFrame) begin
        m_elapsed++;
        if (m_elapsed == RL) begin
          m_ammo = MAXA; m_mode = 0; m_elapsed = 0;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (triggerShot === 1'b1) trig_seen++;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0; startOfFrame = 1'b0; fireKey = 1'b0; reloadKey = 1'b0;
    dirIn = 3'd0; shotFree = 1'b1; pause = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic shoot(input int n, input bit cool_last);
    for (int k = 0; k < n; k++) begin
      fireKey = 1'b1; tick();
      fireKey = 1'b0; tick();
      if (k < n - 1 || cool_last) frames(CD);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (triggerShot !== 1'b0) begin bad++; $display("FAIL rst_trig: got %0d want 0", triggerShot); end
    total++; if (shotDirection !== 3'd0) begin bad++; $display("FAIL rst_dir: got %0d want 0", shotDirection); end
    total++; if (ammoCount !== 4'd8) begin bad++; $display("FAIL rst_ammo: got %0d want 8", ammoCount); end
    total++; if (shotsFired !== 8'd0) begin bad++; $display("FAIL rst_shots: got %0d want 0", shotsFired); end
    total++; if (reloading !== 1'b0) begin bad++; $display("FAIL rst_reloading: got %0d want 0", reloading); end
    total++; if (dut_state() !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dut_state()); end
    // key held across reset release counts as a rise
    resetN = 1'b0; model_reset(); fireKey = 1'b1;
    @(negedge clk);
    resetN = 1'b1;
    tick();
    total++; if (triggerShot !== 1'b1) begin bad++; $display("FAIL held_key_rise: got %0d want 1", triggerShot); end
    fireKey = 1'b0;
  endtask

  task automatic test_single_shot();
    do_reset();
    repeat (10) tick();
    dirIn = 3'd3; fireKey = 1'b1;
    tick();
    total++; if (triggerShot !== 1'b1) begin bad++; $display("FAIL ss_trig: got %0d want 1", triggerShot); end
    total++; if (shotDirection !== 3'd3) begin bad++; $display("FAIL ss_dir: got %0d want 3", shotDirection); end
    total++; if (ammoCount !== 4'd7) begin bad++; $display("FAIL ss_ammo: got %0d want 7", ammoCount); end
    total++; if (shotsFired !== 8'd1) begin bad++; $display("FAIL ss_shots: got %0d want 1", shotsFired); end
    total++; if (dut_state() !== 2'd1) begin bad++; $display("FAIL ss_state: got %0d want 1", dut_state()); end
    dirIn = 3'd5;
    tick();
    total++; if (triggerShot !== 1'b0) begin bad++; $display("FAIL ss_trig_once: got %0d want 0", triggerShot); end
    total++; if (shotDirection !== 3'd3) begin bad++; $display("FAIL ss_dir_hold: got %0d want 3", shotDirection); end
    fireKey = 1'b0;
    frames(CD);
    total++; if (dut_state() !== 2'd0) begin bad++; $display("FAIL ss_idle: got %0d want 0", dut_state()); end
  endtask

  task automatic test_hold_and_repress();
    int base;
    do_reset();
    base = trig_seen;
    fireKey = 1'b1;
    frames(20);
    total++; if (trig_seen - base !== 1) begin bad++; $display("FAIL hold_once: got %0d want 1", trig_seen - base); end
    fireKey = 1'b0; tick();
    fireKey = 1'b1; tick();
    fireKey = 1'b0;
    frames(CD);
    fireKey = 1'b1; tick();
    total++; if (triggerShot !== 1'b1) begin bad++; $display("FAIL repress_6: got %0d want 1", triggerShot); end
    fireKey = 1'b0;
    frames(CD - 1);
    fireKey = 1'b1; tick();
    total++; if (triggerShot !== 1'b0) begin bad++; $display("FAIL repress_5: got %0d want 0", triggerShot); end
    total++; if (ammoCount !== 4'd5) begin bad++; $display("FAIL repress_ammo: got %0d want 5", ammoCount); end
    total++; if (shotsFired !== 8'd3) begin bad++; $display("FAIL repress_shots: got %0d want 3", shotsFired); end
    fireKey = 1'b0;
  endtask

  task automatic test_empty_reload();
    int base;
    do_reset();
    shoot(MAXA, 1'b0);
    total++; if (ammoCount !== 4'd0) begin bad++; $display("FAIL empty_ammo: got %0d want 0", ammoCount); end
    frames(CD - 1);
    total++; if (reloading !== 1'b0) begin bad++; $display("FAIL empty_early: got %0d want 0", reloading); end
    frames(1);
    total++; if (reloading !== 1'b1) begin bad++; $display("FAIL empty_reloading: got %0d want 1", reloading); end
    base = trig_seen;
    for (int i = 0; i < RL - 1; i++) begin
      fireKey = (i % 2 == 0);
      frames(1);
    end
    total++; if (trig_seen - base !== 0) begin bad++; $display("FAIL reload_fire: got %0d want 0", trig_seen - base); end
    total++; if (reloading !== 1'b1) begin bad++; $display("FAIL reload_hold: got %0d want 1", reloading); end
    fireKey = 1'b0;
    frames(1);
    total++; if (ammoCount !== 4'd8) begin bad++; $display("FAIL refill_ammo: got %0d want 8", ammoCount); end
    total++; if (dut_state() !== 2'd0) begin bad++; $display("FAIL refill_idle: got %0d want 0", dut_state()); end
  endtask

  task automatic test_fire_reload_same();
    do_reset();
    shoot(3, 1'b1);
    total++; if (ammoCount !== 4'd5) begin bad++; $display("FAIL fr_pre_ammo: got %0d want 5", ammoCount); end
    fireKey = 1'b1; reloadKey = 1'b1;
    tick();
    total++; if (triggerShot !== 1'b1) begin bad++; $display("FAIL fr_trig: got %0d want 1", triggerShot); end
    total++; if (ammoCount !== 4'd4) begin bad++; $display("FAIL fr_ammo: got %0d want 4", ammoCount); end
    total++; if (dut_state() !== 2'd1) begin bad++; $display("FAIL fr_state: got %0d want 1", dut_state()); end
    fireKey = 1'b0; reloadKey = 1'b0;
    tick();
    frames(CD);
    shotFree = 1'b0; fireKey = 1'b1; reloadKey = 1'b1;
    tick();
    total++; if (triggerShot !== 1'b0) begin bad++; $display("FAIL fr_busy_trig: got %0d want 0", triggerShot); end
    tick();
    total++; if (dut_state() !== 2'd0) begin bad++; $display("FAIL fr_busy_state: got %0d want 0", dut_state()); end
    total++; if (ammoCount !== 4'd4) begin bad++; $display("FAIL fr_busy_ammo: got %0d want 4", ammoCount); end
    fireKey = 1'b0; reloadKey = 1'b0; shotFree = 1'b1;
  endtask

  task automatic test_pause();
    int base;
    do_reset();
    fireKey = 1'b1; tick();
    fireKey = 1'b0;
    frames(3);
    total++; if (dut_cnt() !== 6'd3) begin bad++; $display("FAIL pause_pre_cnt: got %0d want 3", dut_cnt()); end
    base = trig_seen;
    pause = 1'b1; fireKey = 1'b1;
    frames(10);
    total++; if (dut_cnt() !== 6'd3) begin bad++; $display("FAIL pause_cnt: got %0d want 3", dut_cnt()); end
    total++; if (trig_seen - base !== 0) begin bad++; $display("FAIL pause_trig: got %0d want 0", trig_seen - base); end
    total++; if (dut_state() !== 2'd1) begin bad++; $display("FAIL pause_state: got %0d want 1", dut_state()); end
    pause = 1'b0; fireKey = 1'b0;
    frames(2);
    total++; if (dut_state() !== 2'd1) begin bad++; $display("FAIL unpause_2: got %0d want 1", dut_state()); end
    frames(1);
    total++; if (dut_state() !== 2'd0) begin bad++; $display("FAIL unpause_3: got %0d want 0", dut_state()); end
  endtask

  task automatic test_reset_mid_reload();
    do_reset();
    shoot(MAXA, 1'b1);
    frames(10);
    total++; if (reloading !== 1'b1) begin bad++; $display("FAIL mid_reloading: got %0d want 1", reloading); end
    resetN = 1'b0;
    #1;
    total++; if (ammoCount !== 4'd8) begin bad++; $display("FAIL async_ammo: got %0d want 8", ammoCount); end
    total++; if (shotsFired !== 8'd0) begin bad++; $display("FAIL async_shots: got %0d want 0", shotsFired); end
    total++; if (dut_state() !== 2'd0) begin bad++; $display("FAIL async_state: got %0d want 0", dut_state()); end
    total++; if (reloading !== 1'b0) begin bad++; $display("FAIL async_reloading: got %0d want 0", reloading); end
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      fireKey      = ($urandom_range(0, 2) == 0);
      reloadKey    = ($urandom_range(0, 15) == 0);
      startOfFrame = ($urandom_range(0, 5) == 0);
      shotFree     = ($urandom_range(0, 4) != 0);
      dirIn        = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) pause = ~pause;
      tick();
      total++; if (triggerShot !== m_trig) begin bad++; $display("FAIL rnd_trig @%0d: got %0d want %0d", i, triggerShot, m_trig); end
      total++; if (shotDirection !== m_dir) begin bad++; $display("FAIL rnd_dir @%0d: got %0d want %0d", i, shotDirection, m_dir); end
      total++; if (ammoCount !== 4'(m_ammo)) begin bad++; $display("FAIL rnd_ammo @%0d: got %0d want %0d", i, ammoCount, m_ammo); end
      total++; if (shotsFired !== 8'(m_shots)) begin bad++; $display("FAIL rnd_shots @%0d: got %0d want %0d", i, shotsFired, m_shots); end
      total++; if (reloading !== (m_mode == 2)) begin bad++; $display("FAIL rnd_reloading @%0d: got %0d want %0d", i, reloading, m_mode == 2); end
    end
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_hold_and_repress();
    test_empty_reload();
    test_fire_reload_same();
    test_pause();
    test_reset_mid_reload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
